// File: rtl/io_port_adapter_if.sv
// io_port_adapter_if: CPU I/O bus strobes plus TX sink and RX source handshakes
interface io_port_adapter_if;
    logic       IO_clk_e;
    logic       IO_clk_s;
    logic       IO_input_or_output;
    logic       IO_data_or_address;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic       selected;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport slave (
        input  IO_clk_e, IO_clk_s, IO_input_or_output, IO_data_or_address, bus_in,
        input  tx_ready, rx_data, rx_valid,
        output bus_out, bus_drive, selected, tx_data, tx_valid, rx_ready
    );

    modport master (
        output IO_clk_e, IO_clk_s, IO_input_or_output, IO_data_or_address, bus_in,
        output tx_ready, rx_data, rx_valid,
        input  bus_out, bus_drive, selected, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/io_port_adapter.sv
// io_port_adapter: addressable I/O device with select register, TX FIFO and RX FIFO
module io_port_adapter #(
    parameter logic [7:0] DEV_ADDR   = 8'h0F,
    parameter int         FIFO_DEPTH = 4
) (
    input logic              sys_clk,
    input logic              reset,
    io_port_adapter_if.slave io
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic          s_prev_q, e_prev_q, selected_q, tx_ovf_q;
    logic          selected_d, tx_ovf_d;
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [AW-1:0] tx_wp_d, tx_rp_d, rx_wp_d, rx_rp_d;
    logic [CW-1:0] tx_cnt_q, rx_cnt_q, tx_cnt_d, rx_cnt_d;
    logic          s_rise, e_fall, is_out, is_addr;
    logic          tx_full, tx_empty, tx_pop, tx_req, tx_push, ovf_set;
    logic          rx_full, rx_empty, rx_push, rx_pop;
    logic [4:0]    rx_cnt5;
    logic [7:0]    status, rx_head;

    // Edge detection, FIFO handshakes and status word
    always_comb begin
        is_out   = io.IO_input_or_output;
        is_addr  = io.IO_data_or_address;
        s_rise   = io.IO_clk_s & ~s_prev_q;
        e_fall   = ~io.IO_clk_e & e_prev_q;
        tx_full  = tx_cnt_q == CW'(FIFO_DEPTH);
        tx_empty = tx_cnt_q == '0;
        rx_full  = rx_cnt_q == CW'(FIFO_DEPTH);
        rx_empty = rx_cnt_q == '0;
        tx_pop   = ~tx_empty & io.tx_ready;
        tx_req   = s_rise & is_out & ~is_addr & selected_q;
        // A full TX FIFO still accepts a byte when the sink frees a slot this cycle
        tx_push  = tx_req & (~tx_full | tx_pop);
        ovf_set  = tx_req & tx_full & ~tx_pop;
        rx_push  = io.rx_valid & ~rx_full;
        rx_pop   = e_fall & ~is_out & ~is_addr & ~rx_empty;
        rx_cnt5  = 5'(rx_cnt_q);
        rx_head  = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
        status   = {~rx_empty, tx_full, tx_ovf_q, tx_empty, rx_cnt5[4] ? 4'hF : rx_cnt5[3:0]};
    end

    // Next-state values for select, overflow flag, pointers and counts
    always_comb begin
        selected_d = (s_rise & is_out & is_addr) ? (io.bus_in == DEV_ADDR) : selected_q;
        tx_ovf_d   = ovf_set ? 1'b1 : (e_fall & ~is_out & is_addr) ? 1'b0 : tx_ovf_q;
        tx_wp_d    = tx_push ? tx_wp_q + AW'(1) : tx_wp_q;
        tx_rp_d    = tx_pop  ? tx_rp_q + AW'(1) : tx_rp_q;
        rx_wp_d    = rx_push ? rx_wp_q + AW'(1) : rx_wp_q;
        rx_rp_d    = rx_pop  ? rx_rp_q + AW'(1) : rx_rp_q;
        tx_cnt_d   = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d   = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end

    // Control state with synchronous reset; FIFO contents are discarded via pointers
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            s_prev_q   <= 1'b0;
            e_prev_q   <= 1'b0;
            selected_q <= 1'b0;
            tx_ovf_q   <= 1'b0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
        end else begin
            s_prev_q   <= io.IO_clk_s;
            e_prev_q   <= io.IO_clk_e;
            selected_q <= selected_d;
            tx_ovf_q   <= tx_ovf_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_cnt_q   <= rx_cnt_d;
        end
    end

    // FIFO storage writes; stale entries are unreachable once pointers reset
    always_ff @(posedge sys_clk) begin
        if (!reset && tx_push) tx_mem_q[tx_wp_q] <= io.bus_in;
        if (!reset && rx_push) rx_mem_q[rx_wp_q] <= io.rx_data;
    end

    assign io.selected  = selected_q;
    assign io.bus_drive = io.IO_clk_e & ~is_out & selected_q;
    assign io.bus_out   = io.bus_drive ? (is_addr ? status : rx_head) : 8'h00;
    assign io.tx_valid  = ~tx_empty;
    assign io.tx_data   = tx_empty ? 8'h00 : tx_mem_q[tx_rp_q];
    assign io.rx_ready  = ~rx_full;
endmodule

// File: tb/tb_io_port_adapter.sv
// tb_io_port_adapter: directed self-checking bench for io_port_adapter
module tb_io_port_adapter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [7:0] v;

    always #5 clk = ~clk;

    io_port_adapter_if bus();

    io_port_adapter #(.DEV_ADDR(8'h0F), .FIFO_DEPTH(4)) dut (
        .sys_clk(clk),
        .reset(rst),
        .io(bus)
    );

    task automatic out_op(input logic da, input logic [7:0] val);
        @(negedge clk);
        bus.IO_input_or_output = 1'b1;
        bus.IO_data_or_address = da;
        bus.bus_in = val;
        bus.IO_clk_s = 1'b1;
        @(negedge clk);
        bus.IO_clk_s = 1'b0;
    endtask

    task automatic in_op(input logic da, output logic [7:0] val);
        @(negedge clk);
        bus.IO_input_or_output = 1'b0;
        bus.IO_data_or_address = da;
        bus.IO_clk_e = 1'b1;
        @(posedge clk);
        #1 val = bus.bus_out;
        @(negedge clk);
        bus.IO_clk_e = 1'b0;
        @(negedge clk);
    endtask

    task automatic rx_push(input logic [7:0] val);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data = val;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.bus_drive !== 1'b0) begin bad++; $display("FAIL rst_drive got=%b exp=0", bus.bus_drive); end
        total++; if (bus.bus_out !== 8'h00) begin bad++; $display("FAIL rst_bus_out got=%h exp=00", bus.bus_out); end
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", bus.tx_valid); end
        total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL rst_rx_ready got=%b exp=1", bus.rx_ready); end
        total++; if (bus.selected !== 1'b0) begin bad++; $display("FAIL rst_selected got=%b exp=0", bus.selected); end
        rst = 1'b0;
    endtask

    task automatic test_select;
        out_op(1'b1, 8'h0F);
        total++; if (bus.selected !== 1'b1) begin bad++; $display("FAIL sel_match got=%b exp=1", bus.selected); end
        out_op(1'b1, 8'h10);
        total++; if (bus.selected !== 1'b0) begin bad++; $display("FAIL sel_nomatch got=%b exp=0", bus.selected); end
        out_op(1'b0, 8'hAA);
        @(negedge clk);
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL desel_push got=%b exp=0", bus.tx_valid); end
    endtask

    task automatic test_tx_fill;
        logic [7:0] bytes [5];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bus.tx_ready = 1'b0;
        out_op(1'b1, 8'h0F);
        for (int i = 0; i < 5; i++) out_op(1'b0, bytes[i]);
        total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h11) begin bad++; $display("FAIL fill_head got=%b/%h exp=1/11", bus.tx_valid, bus.tx_data); end
        in_op(1'b1, v);
        total++; if (v !== 8'h60) begin bad++; $display("FAIL ovf_status got=%h exp=60", v); end
        in_op(1'b1, v);
        total++; if (v !== 8'h40) begin bad++; $display("FAIL ovf_cleared got=%h exp=40", v); end
    endtask

    task automatic test_tx_drain;
        logic [7:0] exp [4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        @(negedge clk);
        bus.tx_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp[i]) begin bad++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, exp[i]); end
            @(negedge clk);
        end
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", bus.tx_valid); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_rx;
        rx_push(8'h41);
        rx_push(8'h42);
        in_op(1'b1, v);
        total++; if (v !== 8'h92) begin bad++; $display("FAIL rx_status got=%h exp=92", v); end
        in_op(1'b0, v);
        total++; if (v !== 8'h41) begin bad++; $display("FAIL rx_read1 got=%h exp=41", v); end
        in_op(1'b0, v);
        total++; if (v !== 8'h42) begin bad++; $display("FAIL rx_read2 got=%h exp=42", v); end
        in_op(1'b0, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL rx_read_empty got=%h exp=00", v); end
        in_op(1'b1, v);
        total++; if (v !== 8'h10) begin bad++; $display("FAIL rx_no_underflow got=%h exp=10", v); end
    endtask

    task automatic test_hold_e;
        rx_push(8'h55);
        rx_push(8'h66);
        @(negedge clk);
        bus.IO_input_or_output = 1'b0;
        bus.IO_data_or_address = 1'b0;
        bus.IO_clk_e = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++; if (bus.bus_drive !== 1'b1 || bus.bus_out !== 8'h55) begin bad++; $display("FAIL hold_e_%0d got=%b/%h exp=1/55", i, bus.bus_drive, bus.bus_out); end
        end
        @(negedge clk);
        bus.IO_clk_e = 1'b0;
        @(negedge clk);
        in_op(1'b1, v);
        total++; if (v !== 8'h91) begin bad++; $display("FAIL hold_e_one_pop got=%h exp=91", v); end
        in_op(1'b0, v);
        total++; if (v !== 8'h66) begin bad++; $display("FAIL hold_e_next got=%h exp=66", v); end
    endtask

    task automatic test_hold_s;
        @(negedge clk);
        bus.IO_input_or_output = 1'b1;
        bus.IO_data_or_address = 1'b0;
        bus.bus_in = 8'h77;
        bus.IO_clk_s = 1'b1;
        repeat (5) @(negedge clk);
        bus.IO_clk_s = 1'b0;
        total++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h77) begin bad++; $display("FAIL hold_s_head got=%b/%h exp=1/77", bus.tx_valid, bus.tx_data); end
        in_op(1'b1, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL hold_s_status got=%h exp=00", v); end
        @(negedge clk);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL hold_s_one_push got=%b exp=0", bus.tx_valid); end
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        out_op(1'b1, 8'h0F);
        out_op(1'b0, 8'h01);
        out_op(1'b0, 8'h02);
        out_op(1'b0, 8'h03);
        rx_push(8'hA1);
        rx_push(8'hA2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.tx_valid !== 1'b0) begin bad++; $display("FAIL mid_tx_valid got=%b exp=0", bus.tx_valid); end
        total++; if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL mid_rx_ready got=%b exp=1", bus.rx_ready); end
        total++; if (bus.selected !== 1'b0) begin bad++; $display("FAIL mid_selected got=%b exp=0", bus.selected); end
        out_op(1'b1, 8'h0F);
        in_op(1'b1, v);
        total++; if (v !== 8'h10) begin bad++; $display("FAIL mid_status got=%h exp=10", v); end
    endtask

    initial begin
        bus.IO_clk_e = 1'b0;
        bus.IO_clk_s = 1'b0;
        bus.IO_input_or_output = 1'b0;
        bus.IO_data_or_address = 1'b0;
        bus.bus_in = 8'h00;
        bus.tx_ready = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        test_reset();
        test_select();
        test_tx_fill();
        test_tx_drain();
        test_rx();
        test_hold_e();
        test_hold_s();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
